// File: rtl/sys_clk_en_gen.sv
// Lock-qualified clock-enable generator: one fast clock, NUM_CH programmable-rate strobes.
// Strobes run only after PLL lock has been stable; divider/phase updates land on period wraps.
module sys_clk_en_gen #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned DIV_RST   = 100
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       ch_en,
  output logic                    ready,
  output logic                    cfg_busy
);

  localparam int unsigned      LkW    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [LkW-1:0]   LkLast = LkW'(LOCK_WAIT - 1);
  localparam logic [DIV_W-1:0] DivRst = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  typedef enum logic [1:0] {StIdle, StWaitLock, StRun} state_e;

  state_e                         state_q, state_d;
  logic                           lk_meta_q, lk_s_q;
  logic [LkW-1:0]                 lock_cnt_q, lock_cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   div_q, div_d, phase_q, phase_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   sh_div_q, sh_div_d, sh_phase_q, sh_phase_d;
  logic [NUM_CH-1:0]              pending_q, pending_d;
  logic [NUM_CH-1:0]              ch_en_q, ch_en_d;
  logic                           busy_q, busy_d;

  logic [NUM_CH-1:0][DIV_W-1:0]   d_eff, p_eff;
  logic [NUM_CH-1:0]              wrap;
  logic                           run_active, run_entry, accept;

  // Effective period/phase: div 0 behaves as 1, out-of-range phase falls back to 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      d_eff[i] = (div_q[i] == '0) ? DivOne : div_q[i];
      p_eff[i] = (phase_q[i] < d_eff[i]) ? phase_q[i] : '0;
      wrap[i]  = (cnt_q[i] >= d_eff[i] - DivOne);
    end
  end

  always_comb begin
    run_active = (state_q == StRun) && lk_s_q;
    run_entry  = (state_q == StWaitLock) && lk_s_q && (lock_cnt_q == LkLast);
    accept     = cfg_load && !busy_q;

    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      StIdle: begin
        if (lk_s_q) begin
          state_d    = StWaitLock;
          lock_cnt_d = '0;
        end
      end
      StWaitLock: begin
        if (!lk_s_q) begin
          state_d = StIdle;
        end else if (lock_cnt_q == LkLast) begin
          state_d = StRun;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lk_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cnt_d      = cnt_q;
    div_d      = div_q;
    phase_d    = phase_q;
    pending_d  = pending_q;
    ch_en_d    = '0;
    sh_div_d   = sh_div_q;
    sh_phase_d = sh_phase_q;

    for (int i = 0; i < NUM_CH; i++) begin
      if (run_active) begin
        ch_en_d[i] = (cnt_q[i] == p_eff[i]);
        if (wrap[i]) begin
          cnt_d[i] = '0;
          // New settings only take effect at a period boundary.
          if (pending_q[i]) begin
            div_d[i]     = sh_div_q[i];
            phase_d[i]   = sh_phase_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DivOne;
        end
      end else begin
        if (pending_q[i]) begin
          div_d[i]     = sh_div_q[i];
          phase_d[i]   = sh_phase_q[i];
          pending_d[i] = 1'b0;
        end
        if (run_entry) cnt_d[i] = '0;
      end
    end

    // pending_q is clear whenever busy_q is low, so accept never races an apply.
    if (accept) begin
      sh_div_d   = cfg_div;
      sh_phase_d = cfg_phase;
      pending_d  = '1;
    end
    busy_d = accept || (|pending_q);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lk_meta_q  <= 1'b0;
      lk_s_q     <= 1'b0;
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      cnt_q      <= '0;
      div_q      <= {NUM_CH{DivRst}};
      phase_q    <= '0;
      sh_div_q   <= {NUM_CH{DivRst}};
      sh_phase_q <= '0;
      pending_q  <= '0;
      busy_q     <= 1'b0;
      ch_en_q    <= '0;
    end else begin
      lk_meta_q  <= pll_locked;
      lk_s_q     <= lk_meta_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      sh_div_q   <= sh_div_d;
      sh_phase_q <= sh_phase_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      ch_en_q    <= ch_en_d;
    end
  end

  assign ch_en    = ch_en_q;
  assign ready    = (state_q == StRun);
  assign cfg_busy = busy_q;

endmodule

// File: tb/tb_sys_clk_en_gen.sv
// Bench for sys_clk_en_gen: directed lock/reconfig/reset steps plus random traffic,
// checked every cycle against a strobe-timetable reference model.
module tb_sys_clk_en_gen;

  localparam int unsigned NumCh    = 4;
  localparam int unsigned DivW     = 16;
  localparam int unsigned LockWait = 16;
  localparam int unsigned DivRst   = 100;

  logic                   refclk = 1'b0;
  logic                   rst;
  logic                   pll_locked;
  logic [NumCh*DivW-1:0]  cfg_div, cfg_phase;
  logic                   cfg_load;
  logic [NumCh-1:0]       ch_en;
  logic                   ready, cfg_busy;

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  sys_clk_en_gen #(
    .NUM_CH   (NumCh),
    .DIV_W    (DivW),
    .LOCK_WAIT(LockWait),
    .DIV_RST  (DivRst)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_load  (cfg_load),
    .ch_en     (ch_en),
    .ready     (ready),
    .cfg_busy  (cfg_busy)
  );

  // Reference model: lock qualified by run length of synchronised samples,
  // strobes placed by absolute cycle number relative to each period start.
  int             cyc;
  bit             s1, s2;
  int             run_len;
  bit             m_ready, m_busy;
  logic [NumCh-1:0] m_en;
  int             m_div[NumCh], m_ph[NumCh], sh_div[NumCh], sh_ph[NumCh], pstart[NumCh];
  bit             pend[NumCh];

  function automatic int eff_d(int i);
    return (m_div[i] == 0) ? 1 : m_div[i];
  endfunction

  function automatic int eff_p(int i);
    return (m_ph[i] < eff_d(i)) ? m_ph[i] : 0;
  endfunction

  task automatic model_reset();
    s1 = 0; s2 = 0; run_len = 0; m_ready = 0; m_busy = 0; m_en = '0;
    for (int i = 0; i < NumCh; i++) begin
      m_div[i] = DivRst; m_ph[i] = 0; sh_div[i] = DivRst; sh_ph[i] = 0;
      pend[i] = 0; pstart[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit lk, ready_prev, run_act, any_pend, accept;
    cyc++;
    lk = s2; s2 = s1; s1 = pll_locked;
    run_len = lk ? ((run_len < 100000) ? run_len + 1 : run_len) : 0;
    ready_prev = m_ready;
    m_ready = (run_len >= LockWait + 1);
    run_act = ready_prev && lk;
    accept = cfg_load && !m_busy;
    any_pend = 0;
    for (int i = 0; i < NumCh; i++) any_pend |= pend[i];
    for (int i = 0; i < NumCh; i++) begin
      m_en[i] = 1'b0;
      if (run_act) begin
        if (cyc == pstart[i] + eff_p(i) + 1) m_en[i] = 1'b1;
        if (cyc == pstart[i] + eff_d(i)) begin
          pstart[i] = cyc;
          if (pend[i]) begin m_div[i] = sh_div[i]; m_ph[i] = sh_ph[i]; pend[i] = 0; end
        end
      end else if (pend[i]) begin
        m_div[i] = sh_div[i]; m_ph[i] = sh_ph[i]; pend[i] = 0;
      end
      if (!ready_prev && m_ready) pstart[i] = cyc;
    end
    if (accept) begin
      for (int i = 0; i < NumCh; i++) begin
        sh_div[i] = int'(cfg_div[i*DivW +: DivW]);
        sh_ph[i]  = int'(cfg_phase[i*DivW +: DivW]);
        pend[i]   = 1;
      end
    end
    m_busy = accept || any_pend;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("ready", {31'b0, ready}, {31'b0, m_ready});
    check("ch_en", {28'b0, ch_en}, {28'b0, m_en});
    check("cfg_busy", {31'b0, cfg_busy}, {31'b0, m_busy});
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    if (!rst) model_reset();
    else model_edge();
    check_outputs();
  endtask

  task automatic set_ch(input int ch, input int div, input int ph);
    cfg_div[ch*DivW +: DivW]   = DivW'(div);
    cfg_phase[ch*DivW +: DivW] = DivW'(ph);
  endtask

  task automatic load_cfg();
    int n = 0;
    while (cfg_busy !== 1'b0 && n < 300) begin tick(); n++; end
    check("busy_wait", {31'b0, cfg_busy}, 32'd0);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic count_to_ready(input string tag, input int exp);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    check(tag, n, exp);
  endtask

  initial begin
    int n, t_low, t_high;
    cyc = 0;
    rst = 1'b0; pll_locked = 1'b0; cfg_load = 1'b0; cfg_div = '0; cfg_phase = '0;
    model_reset();
    #1;
    check_outputs();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();

    // Lock-up: 2 sync flops, one IDLE->WAIT edge, LOCK_WAIT cycles of waiting.
    pll_locked = 1'b1;
    count_to_ready("lock_time", LockWait + 3);
    repeat (250) tick();

    // Basic divisors and the degenerate div=0 / phase>=div cases.
    set_ch(0, 1, 0); set_ch(1, 2, 0); set_ch(2, 3, 0); set_ch(3, 5, 0);
    load_cfg();
    repeat (40) tick();
    set_ch(0, 0, 0); set_ch(1, 5, 7); set_ch(2, 3, 2); set_ch(3, 7, 3);
    load_cfg();
    repeat (40) tick();

    // Mid-period reconfiguration of ch0 10 -> 4, with a second load while busy.
    set_ch(0, 10, 0);
    load_cfg();
    repeat (30) tick();
    n = 0;
    tick();
    while (ch_en[0] !== 1'b1 && n < 60) begin tick(); n++; end
    check("strobe0_seen", {31'b0, ch_en[0]}, 32'd1);
    repeat (2) tick();
    set_ch(0, 4, 0);
    cfg_load = 1'b1;
    tick();
    check("busy_after_load", {31'b0, cfg_busy}, 32'd1);
    set_ch(0, 7, 1);
    tick();
    cfg_load = 1'b0;
    repeat (40) tick();

    // Single-cycle lock drop in RUN.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    t_low = 0; t_high = 0;
    for (int k = 1; k <= 100 && t_high == 0; k++) begin
      tick();
      if (ready === 1'b0 && t_low == 0) t_low = k;
      if (ready === 1'b1 && t_low != 0) t_high = k;
    end
    check("drop_ready_low", t_low, 2);
    check("relock_time", t_high, LockWait + 3);

    // Glitch during WAIT_LOCK when its counter reads 10.
    pll_locked = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (11) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    count_to_ready("glitch_relock", LockWait + 3);

    // Random reconfiguration and lock drops.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int c = 0; c < NumCh; c++) set_ch(c, $urandom_range(0, 12), $urandom_range(0, 15));
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      pll_locked = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    cfg_load = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    check("ready_before_reset", {31'b0, ready}, 32'd1);

    // Asynchronous reset in RUN while a reconfiguration is pending.
    for (int c = 0; c < NumCh; c++) set_ch(c, 60, 5);
    load_cfg();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) tick();
    rst = 1'b1;
    count_to_ready("post_reset_lock", LockWait + 3);
    repeat (220) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
